// File: rtl/audio_nios_onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves, s1-wins write-collision arbitration and a zero-fill engine.
// Define AUDIO_NIOS_ONCHIP_MEMORY_DP_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module audio_nios_onchip_memory_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 80000,
  parameter int ADDR_WIDTH = 17,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  reset_req,
  input  logic [ADDR_WIDTH-1:0] s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [BE_WIDTH-1:0]   s1_byteenable,
  input  logic [DATA_WIDTH-1:0] s1_writedata,
  output logic [DATA_WIDTH-1:0] s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0] s2_address,
  input  logic                  s2_chipselect,
  input  logic                  s2_read,
  input  logic                  s2_write,
  input  logic [BE_WIDTH-1:0]   s2_byteenable,
  input  logic [DATA_WIDTH-1:0] s2_writedata,
  output logic [DATA_WIDTH-1:0] s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  s2_waitrequest,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  collision
);

  localparam int                    MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   clr_cnt_reg;
  logic                    clear_busy_reg;
  logic                    collision_reg;

  logic                    stall;
  logic                    s1_in_range, s2_in_range;
  logic                    s1_acc, s2_acc;
  logic                    s1_rd_acc, s2_rd_acc;
  logic                    s1_wr_en, s2_wr_en;
  logic                    s2_drop;
  logic                    clear_wr;

  logic [MEM_AW-1:0]       a_addr, b_addr;
  logic                    a_we, b_we;
  logic [BE_WIDTH-1:0]     a_be;
  logic [DATA_WIDTH-1:0]   a_data;
  logic [DATA_WIDTH-1:0]   ram1_q, ram2_q;

  logic                    v1_reg, v2_reg;
  logic                    zero1_reg, zero2_reg;
  logic [DATA_WIDTH-1:0]   rd1, rd2;

  assign stall          = ~clken | reset_req | clear_busy_reg;
  assign s1_waitrequest = stall;
  assign s2_waitrequest = stall;

  assign s1_in_range = {1'b0, s1_address} < DEPTH_EXT;
  assign s2_in_range = {1'b0, s2_address} < DEPTH_EXT;
  assign s1_acc      = s1_chipselect & (s1_read | s1_write) & ~stall;
  assign s2_acc      = s2_chipselect & (s2_read | s2_write) & ~stall;
  // read+write together on a port is a write, so reads require ~write
  assign s1_rd_acc   = s1_acc & ~s1_write;
  assign s2_rd_acc   = s2_acc & ~s2_write;
  assign s1_wr_en    = s1_acc & s1_write & s1_in_range;
  assign s2_wr_en    = s2_acc & s2_write & s2_in_range;
  assign s2_drop     = s1_wr_en & s2_wr_en & (s1_address == s2_address);
  assign clear_wr    = (state_reg == CLEAR) & clken & ~reset_req;

  // The clear engine borrows port A; host ports are stalled while it runs.
  assign a_addr = clear_wr ? clr_cnt_reg[MEM_AW-1:0] : s1_address[MEM_AW-1:0];
  assign a_we   = clear_wr | s1_wr_en;
  assign a_be   = clear_wr ? '1 : s1_byteenable;
  assign a_data = clear_wr ? '0 : s1_writedata;
  assign b_addr = s2_address[MEM_AW-1:0];
  assign b_we   = s2_wr_en & ~s2_drop;

  genvar gi;
  generate
    for (gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] q1_reg;
      logic [7:0] q2_reg;

      always_ff @(posedge clk) begin
        if (a_we && a_be[gi]) begin
          mem[a_addr] <= a_data[gi*8 +: 8];
        end
        if (b_we && s2_byteenable[gi]) begin
          mem[b_addr] <= s2_writedata[gi*8 +: 8];
        end
        if (s1_rd_acc && s1_in_range) begin
          q1_reg <= mem[a_addr];
        end
        if (s2_rd_acc && s2_in_range) begin
          q2_reg <= mem[b_addr];
        end
      end

      assign ram1_q[gi*8 +: 8] = q1_reg;
      assign ram2_q[gi*8 +: 8] = q2_reg;
    end
  endgenerate

  // zeroX_reg forces 0 after reset and for out-of-range reads, leaving the RAM output register reset-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      zero1_reg     <= 1'b1;
      zero2_reg     <= 1'b1;
      collision_reg <= 1'b0;
    end else begin
      collision_reg <= s2_drop;
      if (clken) begin
        v1_reg <= s1_rd_acc;
        v2_reg <= s2_rd_acc;
        if (s1_rd_acc) begin
          zero1_reg <= ~s1_in_range;
        end
        if (s2_rd_acc) begin
          zero2_reg <= ~s2_in_range;
        end
      end
    end
  end

  assign rd1 = zero1_reg ? '0 : ram1_q;
  assign rd2 = zero2_reg ? '0 : ram2_q;

`ifdef AUDIO_NIOS_ONCHIP_MEMORY_DP_OUTREG_EN
  logic                  v1_out_reg, v2_out_reg;
  logic [DATA_WIDTH-1:0] d1_out_reg, d2_out_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_out_reg <= 1'b0;
      v2_out_reg <= 1'b0;
      d1_out_reg <= '0;
      d2_out_reg <= '0;
    end else if (clken) begin
      v1_out_reg <= v1_reg;
      v2_out_reg <= v2_reg;
      if (v1_reg) begin
        d1_out_reg <= rd1;
      end
      if (v2_reg) begin
        d2_out_reg <= rd2;
      end
    end
  end

  assign s1_readdata      = d1_out_reg;
  assign s2_readdata      = d2_out_reg;
  assign s1_readdatavalid = v1_out_reg & clken;
  assign s2_readdatavalid = v2_out_reg & clken;
`else
  assign s1_readdata      = rd1;
  assign s2_readdata      = rd2;
  // A held strobe only counts in enabled cycles, so it completes once clken returns.
  assign s1_readdatavalid = v1_reg & clken;
  assign s2_readdatavalid = v2_reg & clken;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      clr_cnt_reg    <= '0;
      clear_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clken && clear_req) begin
            state_reg      <= CLEAR;
            clr_cnt_reg    <= '0;
            clear_busy_reg <= 1'b1;
          end
        end
        CLEAR: begin
          if (clear_wr) begin
            if (clr_cnt_reg == LAST_ADDR) begin
              state_reg      <= IDLE;
              clear_busy_reg <= 1'b0;
            end else begin
              clr_cnt_reg <= clr_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg      <= IDLE;
          clear_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign clear_busy = clear_busy_reg;
  assign collision  = collision_reg;

endmodule

// File: tb/tb_audio_nios_onchip_memory_dp.sv
// Self-checking bench for audio_nios_onchip_memory_dp: small-depth build, word-level memory model with read queues.
module tb_audio_nios_onchip_memory_dp;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int BW    = DW / 8;
`ifdef AUDIO_NIOS_ONCHIP_MEMORY_DP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset, clken, reset_req, clear_req;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [BW-1:0] s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;
  logic          clear_busy, collision;

  always #5 clk = ~clk;

  audio_nios_onchip_memory_dp #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
    .clear_req(clear_req), .clear_busy(clear_busy), .collision(collision)
  );

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] got1_q[$], got2_q[$], exp1_q[$], exp2_q[$];
  int            gc1_q[$], gc2_q[$], ec1_q[$], ec2_q[$];
  bit            exp_coll;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (s1_readdatavalid) begin
      got1_q.push_back(s1_readdata);
      gc1_q.push_back(cyc_cnt);
    end
    if (s2_readdatavalid) begin
      got2_q.push_back(s2_readdata);
      gc2_q.push_back(cyc_cnt);
    end
  end

  function automatic logic [DW-1:0] lane_mask(input logic [BW-1:0] be);
    logic [DW-1:0] m;
    for (int b = 0; b < BW; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
  endtask

  task automatic cmd1(input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [BW-1:0] be, input logic [DW-1:0] d);
    s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
    s1_address = a; s1_byteenable = be; s1_writedata = d;
  endtask

  task automatic cmd2(input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [BW-1:0] be, input logic [DW-1:0] d);
    s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
    s2_address = a; s2_byteenable = be; s2_writedata = d;
  endtask

  // Reference model: apply the currently driven commands to the word array, then clock.
  task automatic step();
    bit go, w1, w2;
    go = clken && !reset_req;
    exp_coll = 0;
    if (go && s1_chipselect && s1_read && !s1_write) begin
      exp1_q.push_back((s1_address < DEPTH) ? model[s1_address] : '0);
      ec1_q.push_back(cyc_cnt + LAT);
    end
    if (go && s2_chipselect && s2_read && !s2_write) begin
      exp2_q.push_back((s2_address < DEPTH) ? model[s2_address] : '0);
      ec2_q.push_back(cyc_cnt + LAT);
    end
    w1 = go && s1_chipselect && s1_write && (s1_address < DEPTH);
    w2 = go && s2_chipselect && s2_write && (s2_address < DEPTH);
    if (w1 && w2 && s1_address == s2_address) begin
      w2 = 0;
      exp_coll = 1;
    end
    if (w1) model[s1_address] = (model[s1_address] & ~lane_mask(s1_byteenable)) |
                                (s1_writedata & lane_mask(s1_byteenable));
    if (w2) model[s2_address] = (model[s2_address] & ~lane_mask(s2_byteenable)) |
                                (s2_writedata & lane_mask(s2_byteenable));
    tick();
  endtask

  task automatic flush_queues();
    got1_q.delete(); got2_q.delete(); gc1_q.delete(); gc2_q.delete();
    exp1_q.delete(); exp2_q.delete(); ec1_q.delete(); ec2_q.delete();
  endtask

  task automatic test_reset();
    reset = 1; clken = 1; reset_req = 0; clear_req = 0;
    idle();
    cmd1(0, 0, '0, '0, '0); cmd2(0, 0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    tick();
    checks++; if (s1_readdata !== '0) begin errors++; $display("FAIL reset_s1_readdata got %h want 0", s1_readdata); end
    checks++; if (s2_readdata !== '0) begin errors++; $display("FAIL reset_s2_readdata got %h want 0", s2_readdata); end
    checks++; if (s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_s1_rdv got %b want 0", s1_readdatavalid); end
    checks++; if (s2_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_s2_rdv got %b want 0", s2_readdatavalid); end
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy got %b want 0", clear_busy); end
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision got %b want 0", collision); end
    checks++; if (s1_waitrequest !== 1'b0 || s2_waitrequest !== 1'b0) begin
      errors++; $display("FAIL reset_waitrequest got %b%b want 00", s1_waitrequest, s2_waitrequest);
    end
  endtask

  task automatic test_clear();
    int busy_cnt, bad_wait, nonzero;
    bit first_busy;
    for (int a = 0; a < DEPTH; a++) begin
      cmd1(0, 1, AW'(a), '1, '1);
      step();
    end
    idle();
    clear_req = 1;
    tick();
    clear_req = 0;
    first_busy = clear_busy;
    busy_cnt = 0; bad_wait = 0;
    for (int i = 0; i < DEPTH + 10; i++) begin
      if (clear_busy) busy_cnt++;
      if (s1_waitrequest !== clear_busy || s2_waitrequest !== clear_busy) bad_wait++;
      tick();
    end
    checks++; if (first_busy !== 1'b1) begin errors++; $display("FAIL clear_busy_start got %b want 1", first_busy); end
    checks++; if (busy_cnt != DEPTH) begin errors++; $display("FAIL clear_busy_cycles got %0d want %0d", busy_cnt, DEPTH); end
    checks++; if (bad_wait != 0) begin errors++; $display("FAIL clear_waitrequest got %0d bad cycles want 0", bad_wait); end
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    flush_queues();
    for (int a = 0; a < DEPTH; a++) begin
      cmd1(1, 0, AW'(a), '0, '0);
      cmd2(1, 0, AW'(DEPTH - 1 - a), '0, '0);
      step();
    end
    idle();
    repeat (LAT + 2) tick();
    nonzero = 0;
    foreach (got1_q[i]) if (got1_q[i] !== '0) nonzero++;
    foreach (got2_q[i]) if (got2_q[i] !== '0) nonzero++;
    checks++; if (got1_q.size() != DEPTH || got2_q.size() != DEPTH) begin
      errors++; $display("FAIL clear_read_count got %0d/%0d want %0d", got1_q.size(), got2_q.size(), DEPTH);
    end
    checks++; if (nonzero != 0) begin errors++; $display("FAIL clear_contents got %0d nonzero words want 0", nonzero); end
  endtask

  task automatic test_basic();
    int t0;
    flush_queues();
    cmd1(0, 1, 5'd10, 4'hF, 32'hDEADBEEF);
    step();
    idle();
    cmd2(1, 0, 5'd10, '0, '0);
    t0 = cyc_cnt + LAT;
    step();
    idle();
    repeat (LAT + 2) tick();
    checks++; if (got1_q.size() != 0) begin errors++; $display("FAIL basic_s1_spurious got %0d valids want 0", got1_q.size()); end
    checks++;
    if (got2_q.size() != 1) begin
      errors++; $display("FAIL basic_count got %0d valids want 1", got2_q.size());
    end else begin
      if (got2_q[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data got %h want deadbeef", got2_q[0]); end
      checks++;
      if (gc2_q[0] != t0) begin errors++; $display("FAIL basic_latency got cycle %0d want %0d", gc2_q[0], t0); end
    end
  endtask

  task automatic test_byteenable();
    flush_queues();
    cmd1(0, 1, 5'd5, 4'hF, 32'h11223344); step();
    cmd1(0, 1, 5'd5, 4'b0101, 32'hAABBCCDD); step();
    cmd1(0, 1, 5'd5, 4'b0000, 32'hFFFFFFFF); step();
    cmd1(1, 0, 5'd5, '0, '0); step();
    idle();
    repeat (LAT + 2) tick();
    checks++;
    if (got1_q.size() != 1 || got1_q[0] !== 32'h11BB33DD) begin
      errors++; $display("FAIL byteenable_data got %h (n=%0d) want 11bb33dd", (got1_q.size() != 0) ? got1_q[0] : 'x, got1_q.size());
    end
  endtask

  task automatic test_collision();
    flush_queues();
    cmd1(0, 1, 5'd7, 4'hF, 32'h1);
    cmd2(0, 1, 5'd7, 4'hF, 32'h2);
    step();
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL collision_pulse got %b want 1", collision); end
    idle();
    tick();
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL collision_width got %b want 0", collision); end
    cmd2(1, 0, 5'd7, '0, '0); step();
    idle();
    repeat (LAT + 2) tick();
    checks++;
    if (got2_q.size() != 1 || got2_q[0] !== 32'h1) begin
      errors++; $display("FAIL collision_winner got %h (n=%0d) want 00000001", (got2_q.size() != 0) ? got2_q[0] : 'x, got2_q.size());
    end
  endtask

  task automatic test_read_during_write();
    flush_queues();
    cmd1(0, 1, 5'd3, 4'hF, 32'h55); step();
    cmd1(1, 0, 5'd3, '0, '0);
    cmd2(0, 1, 5'd3, 4'hF, 32'h66);
    step();
    idle();
    cmd1(1, 0, 5'd3, '0, '0); step();
    idle();
    repeat (LAT + 2) tick();
    checks++;
    if (got1_q.size() != 2) begin
      errors++; $display("FAIL rdw_count got %0d want 2", got1_q.size());
    end else begin
      if (got1_q[0] !== 32'h55) begin errors++; $display("FAIL rdw_old got %h want 00000055", got1_q[0]); end
      checks++;
      if (got1_q[1] !== 32'h66) begin errors++; $display("FAIL rdw_new got %h want 00000066", got1_q[1]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] want0;
    flush_queues();
    want0 = model[0];
    cmd1(0, 1, AW'(DEPTH), 4'hF, 32'hCAFEF00D); step();
    cmd1(1, 0, AW'(DEPTH), '0, '0);
    cmd2(1, 0, 5'd31, '0, '0);
    step();
    cmd1(1, 0, 5'd0, '0, '0);
    idle();
    cmd1(1, 0, 5'd0, '0, '0);
    step();
    idle();
    repeat (LAT + 2) tick();
    checks++;
    if (got1_q.size() != 2) begin
      errors++; $display("FAIL oor_s1_count got %0d want 2", got1_q.size());
    end else begin
      if (got1_q[0] !== '0) begin errors++; $display("FAIL oor_s1_data got %h want 0", got1_q[0]); end
      checks++;
      if (got1_q[1] !== want0) begin errors++; $display("FAIL oor_write_dropped got %h want %h", got1_q[1], want0); end
    end
    checks++;
    if (got2_q.size() != 1 || got2_q[0] !== '0) begin
      errors++; $display("FAIL oor_s2_read got %h (n=%0d) want 0", (got2_q.size() != 0) ? got2_q[0] : 'x, got2_q.size());
    end
  endtask

  task automatic test_clken_stall();
    int low_valid;
    for (int a = 1; a <= 4; a++) begin
      cmd2(0, 1, AW'(a), 4'hF, $urandom);
      step();
    end
    idle();
    flush_queues();
    cmd1(1, 0, 5'd1, '0, '0); step();
    cmd1(1, 0, 5'd2, '0, '0); step();
    clken = 0;
    cmd1(1, 0, 5'd3, '0, '0);
    low_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      if (s1_readdatavalid !== 1'b0) low_valid++;
      step();
    end
    clken = 1;
    step();
    cmd1(1, 0, 5'd4, '0, '0); step();
    idle();
    repeat (LAT + 3) tick();
    checks++; if (low_valid != 0) begin errors++; $display("FAIL clken_low_valid got %0d strobes want 0", low_valid); end
    checks++;
    if (got1_q.size() != 4) begin
      errors++; $display("FAIL clken_count got %0d want 4", got1_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0) checks++;
        if (got1_q[i] !== model[i + 1]) begin
          errors++; $display("FAIL clken_order[%0d] got %h want %h", i, got1_q[i], model[i + 1]);
        end
      end
    end
  endtask

  task automatic test_random();
    int op;
    logic [AW-1:0] a;
    flush_queues();
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < 2; p++) begin
        op = $urandom_range(0, 3);
        a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 31)) : AW'($urandom_range(0, DEPTH - 1));
        if (p == 0) cmd1(op == 1 || op == 3, op >= 2, a, BW'($urandom), $urandom);
        else        cmd2(op == 1 || op == 3, op >= 2, a, BW'($urandom), $urandom);
      end
      reset_req = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (s1_waitrequest !== reset_req || s2_waitrequest !== reset_req) begin
        errors++; $display("FAIL rand_waitrequest got %b%b want %b", s1_waitrequest, s2_waitrequest, reset_req);
      end
      step();
      checks++;
      if (collision !== exp_coll) begin errors++; $display("FAIL rand_collision got %b want %b", collision, exp_coll); end
    end
    reset_req = 0;
    idle();
    repeat (LAT + 2) tick();
    checks++;
    if (got1_q.size() != exp1_q.size() || got2_q.size() != exp2_q.size()) begin
      errors++;
      $display("FAIL rand_counts got %0d/%0d want %0d/%0d", got1_q.size(), got2_q.size(), exp1_q.size(), exp2_q.size());
    end else begin
      foreach (exp1_q[i]) begin
        checks++;
        if (got1_q[i] !== exp1_q[i] || gc1_q[i] != ec1_q[i]) begin
          errors++; $display("FAIL rand_s1[%0d] got %h@%0d want %h@%0d", i, got1_q[i], gc1_q[i], exp1_q[i], ec1_q[i]);
        end
      end
      foreach (exp2_q[i]) begin
        checks++;
        if (got2_q[i] !== exp2_q[i] || gc2_q[i] != ec2_q[i]) begin
          errors++; $display("FAIL rand_s2[%0d] got %h@%0d want %h@%0d", i, got2_q[i], gc2_q[i], exp2_q[i], ec2_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    clear_req = 1;
    tick();
    clear_req = 0;
    repeat (8) tick();
    checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL midclear_running got %b want 1", clear_busy); end
    #2 reset = 1;
    #1;
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL midclear_async got %b want 0", clear_busy); end
    #1 reset = 0;
    tick();
    checks++; if (clear_busy !== 1'b0 || s1_waitrequest !== 1'b0) begin
      errors++; $display("FAIL midclear_idle got busy %b wait %b want 0 0", clear_busy, s1_waitrequest);
    end
    flush_queues();
    cmd1(1, 0, 5'd2, '0, '0);
    step();
    idle();
    reset = 1;
    #2 reset = 0;
    repeat (LAT + 2) tick();
    checks++; if (got1_q.size() != 0) begin errors++; $display("FAIL midread_cancel got %0d valids want 0", got1_q.size()); end
    checks++; if (s1_readdata !== '0) begin errors++; $display("FAIL midread_readdata got %h want 0", s1_readdata); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_basic();
    test_byteenable();
    test_collision();
    test_read_during_write();
    test_out_of_range();
    test_clken_stall();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc_cnt);
    $fatal(1, "watchdog");
  end
endmodule
